// File: rtl/sdemux_stream.sv
// Registered 1-to-N valid/ready stream demultiplexer with one-entry buffer per channel.
// Optional broadcast to all channels is built when SDEMUX_BROADCAST_EN is defined.
module sdemux_stream #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      drop_err,
    output logic [7:0]                drop_cnt
);

    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);
    localparam logic [7:0]     CNT_MAX  = 8'hFF;

    logic [CHANNELS-1:0]            out_valid_q, out_valid_d;
    logic [CHANNELS-1:0][WIDTH-1:0] data_q, data_d;
    logic                           drop_err_q, drop_err_d;
    logic [7:0]                     drop_cnt_q, drop_cnt_d;

    logic                in_range;
    logic                bcast;
    logic                accept;
    logic                drop;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] slot_free;
    logic [CHANNELS-1:0] wr;

`ifdef SDEMUX_BROADCAST_EN
    assign bcast = in_bcast;
`else
    logic unused_bcast;
    assign unused_bcast = in_bcast;
    assign bcast        = 1'b0;
`endif

    // Only the addressed channel's state gates in_ready, so channels never block each other.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        in_range  = ({1'b0, in_sel} < CH_LIMIT);
        hit       = '0;
        slot_free = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            hit[k]       = in_range && (in_sel == SEL_W'(k));
            slot_free[k] = !out_valid_q[k] || out_ready[k];
        end

        if (bcast) begin
            in_ready = &slot_free;
        end else if (in_range) begin
            in_ready = |(hit & slot_free);
        end else begin
            in_ready = 1'b1;
        end

        accept = in_valid && in_ready;
        drop   = accept && !bcast && !in_range;
        wr     = '0;
        if (accept) begin
            wr = bcast ? {CHANNELS{1'b1}} : hit;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        for (int k = 0; k < CHANNELS; k++) begin
            if (wr[k]) begin
                out_valid_d[k] = 1'b1;
                data_d[k]      = in_data;
            end else if (out_ready[k]) begin
                out_valid_d[k] = 1'b0;
            end
        end

        drop_err_d = drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            // NOTE: the data registers are reset too, because out_data must read zero after reset.
            data_q      <= '0;
            drop_err_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            drop_err_q  <= drop_err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign drop_err  = drop_err_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_sdemux_stream.sv
// Directed self-checking bench for sdemux_stream: an 8-channel instance for routing,
// backpressure, reset and broadcast, and a 6-channel instance for out-of-range drops.
module tb_sdemux_stream;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-channel instance
    logic          in_valid_a, in_ready_a, in_bcast_a, drop_err_a;
    logic [W-1:0]  in_data_a;
    logic [2:0]    in_sel_a;
    logic [7:0]    out_valid_a, out_ready_a, drop_cnt_a;
    logic [8*W-1:0] out_data_a;

    // 6-channel instance
    logic          in_valid_b, in_ready_b, in_bcast_b, drop_err_b;
    logic [W-1:0]  in_data_b;
    logic [2:0]    in_sel_b;
    logic [5:0]    out_valid_b, out_ready_b;
    logic [7:0]    drop_cnt_b;
    logic [6*W-1:0] out_data_b;

    sdemux_stream #(.WIDTH(W), .CHANNELS(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .in_sel(in_sel_a), .in_bcast(in_bcast_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .drop_err(drop_err_a), .drop_cnt(drop_cnt_a)
    );

    sdemux_stream #(.WIDTH(W), .CHANNELS(6)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .in_sel(in_sel_b), .in_bcast(in_bcast_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .drop_err(drop_err_b), .drop_cnt(drop_cnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] ch_a(input int k);
        return out_data_a[k*W +: W];
    endfunction

    initial begin
        rst_n       = 1'b0;
        in_valid_a  = 1'b0; in_data_a = '0; in_sel_a = '0; in_bcast_a = 1'b0;
        in_valid_b  = 1'b0; in_data_b = '0; in_sel_b = '0; in_bcast_b = 1'b0;
        out_ready_a = 8'hFF;
        out_ready_b = 6'h3F;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid",   {24'd0, out_valid_a}, 32'h0);
        check("rst_data",    {31'd0, out_data_a == '0}, 32'h1);
        check("rst_drop",    {31'd0, drop_err_b}, 32'h0);
        check("rst_cnt",     {24'd0, drop_cnt_b}, 32'h0);
        rst_n = 1'b1;
        step();

        // Route 0x1234 to channel 3, then drain
        in_valid_a = 1'b1; in_sel_a = 3'd3; in_data_a = 16'h1234;
        #1 check("route_rdy", {31'd0, in_ready_a}, 32'h1);
        step();
        in_valid_a = 1'b0;
        check("route_valid", {24'd0, out_valid_a}, 32'h08);
        check("route_data",  {16'd0, ch_a(3)}, 32'h1234);
        step();
        check("drain_valid", {24'd0, out_valid_a}, 32'h00);
        check("drain_keep",  {16'd0, ch_a(3)}, 32'h1234);

        // Back-to-back writes into one channel at full throughput
        for (int i = 0; i < 3; i++) begin
            in_valid_a = 1'b1; in_sel_a = 3'd1; in_data_a = 16'h0100 + 16'(i);
            #1 check("b2b_rdy", {31'd0, in_ready_a}, 32'h1);
            step();
            check("b2b_data", {16'd0, ch_a(1)}, 32'h0100 + i);
        end
        in_valid_a = 1'b0;
        step();

        // Backpressure on channel 2, independence of channel 5
        out_ready_a = 8'hFB;
        in_valid_a = 1'b1; in_sel_a = 3'd2; in_data_a = 16'hAAAA;
        #1 check("bp_rdy1", {31'd0, in_ready_a}, 32'h1);
        step();
        in_sel_a = 3'd5; in_data_a = 16'h5555;
        #1 check("ind_rdy", {31'd0, in_ready_a}, 32'h1);
        step();
        check("ind_valid", {24'd0, out_valid_a}, 32'h24);
        check("ind_data",  {16'd0, ch_a(5)}, 32'h5555);
        in_sel_a = 3'd2; in_data_a = 16'hBBBB;
        #1 check("bp_rdy2", {31'd0, in_ready_a}, 32'h0);
        step();
        check("bp_hold_v", {24'd0, out_valid_a}, 32'h04);
        check("bp_hold_d", {16'd0, ch_a(2)}, 32'hAAAA);
        out_ready_a = 8'hFF;
        #1 check("bp_rdy3", {31'd0, in_ready_a}, 32'h1);
        step();
        in_valid_a = 1'b0;
        check("bp_new_v", {24'd0, out_valid_a}, 32'h04);
        check("bp_new_d", {16'd0, ch_a(2)}, 32'hBBBB);
        step();
        check("bp_empty", {24'd0, out_valid_a}, 32'h00);

        // Out-of-range drops on the 6-channel instance, channel 0 held full
        out_ready_b = 6'h3E;
        in_valid_b = 1'b1; in_sel_b = 3'd0; in_data_b = 16'h0D0D;
        step();
        for (int i = 0; i < 3; i++) begin
            in_sel_b = 3'd7; in_data_b = 16'hDEAD;
            #1 check("drop_rdy", {31'd0, in_ready_b}, 32'h1);
            step();
            check("drop_pulse", {31'd0, drop_err_b}, 32'h1);
        end
        in_valid_b = 1'b0;
        step();
        check("drop_end",   {31'd0, drop_err_b}, 32'h0);
        check("drop_cnt3",  {24'd0, drop_cnt_b}, 32'h3);
        check("drop_vkeep", {26'd0, out_valid_b}, 32'h01);
        check("drop_dkeep", {16'd0, out_data_b[0 +: W]}, 32'h0D0D);
        in_valid_b = 1'b1; in_sel_b = 3'd6;
        repeat (300) step();
        in_valid_b = 1'b0;
        step();
        check("drop_sat", {24'd0, drop_cnt_b}, 32'hFF);

        // Asynchronous reset between edges with channels 0, 1, 4 full
        out_ready_a = 8'h00;
        in_valid_a = 1'b1;
        in_sel_a = 3'd0; in_data_a = 16'h1111; step();
        in_sel_a = 3'd1; in_data_a = 16'h2222; step();
        in_sel_a = 3'd4; in_data_a = 16'h4444; step();
        in_valid_a = 1'b0;
        check("pre_rst_v", {24'd0, out_valid_a}, 32'h13);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {24'd0, out_valid_a}, 32'h0);
        check("arst_data",  {31'd0, out_data_a == '0}, 32'h1);
        check("arst_cnt",   {24'd0, drop_cnt_b}, 32'h0);
        check("arst_vb",    {26'd0, out_valid_b}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready_a = 8'hFF;
        step();

        // Broadcast request with channel 6 full and blocked
        out_ready_a = 8'hBF;
        in_valid_a = 1'b1; in_sel_a = 3'd6; in_data_a = 16'h6666;
        step();
        in_bcast_a = 1'b1; in_sel_a = 3'd2; in_data_a = 16'hCAFE;
`ifdef SDEMUX_BROADCAST_EN
        #1 check("bc_rdy0", {31'd0, in_ready_a}, 32'h0);
        step();
        out_ready_a = 8'hFF;
        #1 check("bc_rdy1", {31'd0, in_ready_a}, 32'h1);
        step();
        in_valid_a = 1'b0; in_bcast_a = 1'b0;
        check("bc_valid", {24'd0, out_valid_a}, 32'hFF);
        for (int k = 0; k < 8; k++) check("bc_data", {16'd0, ch_a(k)}, 32'hCAFE);
`else
        #1 check("nobc_rdy", {31'd0, in_ready_a}, 32'h1);
        step();
        in_valid_a = 1'b0; in_bcast_a = 1'b0;
        check("nobc_valid", {24'd0, out_valid_a}, 32'h44);
        check("nobc_d2",    {16'd0, ch_a(2)}, 32'hCAFE);
        check("nobc_d6",    {16'd0, ch_a(6)}, 32'h6666);
        check("nobc_d0",    {16'd0, ch_a(0)}, 32'h0000);
        out_ready_a = 8'hFF;
`endif
        step();
        check("final_empty", {24'd0, out_valid_a}, 32'h00);
        check("final_cnt_a", {24'd0, drop_cnt_a}, 32'h0);
        check("final_err_a", {31'd0, drop_err_a}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdemux_stream.md
# sdemux_stream

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshakes on the input and on every output channel. Each accepted input word is routed by `in_sel` to one output channel and held there in a one-entry register until that channel's consumer takes it. The block is the sequential successor of the gate-level two-way demux and sits between a single producer and N independent consumers in the datapath.

## Interface
- `WIDTH`, 16, data word width in bits (≥1)
- `CHANNELS`, 8, number of output channels (2..256); `SEL_W = max(1, $clog2(CHANNELS))` is a derived localparam
- `clk` input 1 — sole clock, all state updates on rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `in_valid` input 1 — producer has a word
- `in_ready` output 1 — block accepts word this cycle
- `in_data` input WIDTH — input word
- `in_sel` input SEL_W — destination channel index
- `in_bcast` input 1 — broadcast request (see Configuration)
- `out_valid` output CHANNELS — bit k: channel k register holds a word
- `out_ready` input CHANNELS — bit k: consumer k takes the word
- `out_data` output CHANNELS*WIDTH — channel k occupies bits [k*WIDTH +: WIDTH]
- `drop_err` output 1 — one-cycle pulse: an out-of-range word was discarded
- `drop_cnt` output 8 — saturating count of discarded words

## Operation
- Reset: `out_valid`=0, `out_data`=0, `drop_err`=0, `drop_cnt`=0. Buffered words are lost on mid-operation reset; no partial transfer survives.
- Per-channel state: EMPTY (`out_valid[k]`=0) or FULL (`out_valid[k]`=1).
  - EMPTY → FULL: input word accepted for k.
  - FULL → EMPTY: `out_ready[k]`=1 and no new word accepted for k.
  - FULL → FULL with new data: `out_ready[k]`=1 and a new word accepted for k in the same cycle.
  - FULL stays FULL with data unchanged while `out_ready[k]`=0.
- Transfers: input transfers when `in_valid && in_ready`; output k transfers when `out_valid[k] && out_ready[k]`.
- `in_ready` is combinational from `in_sel`, channel state and `out_ready`:
  - `in_sel` < CHANNELS: `in_ready` = `!out_valid[in_sel] || out_ready[in_sel]`.
  - `in_sel` ≥ CHANNELS: `in_ready`=1. The word is discarded, `drop_err` pulses high the following cycle, and `drop_cnt` increments, saturating at 255.
- Words to different channels never block each other. Only the addressed channel's state gates `in_ready`.
- `out_data[k]` changes only on an accepted write to k. `out_data` is not cleared on drain.
- Per-channel ordering is preserved; the block applies no ordering across channels.

## Timing
- Latency: a word accepted at edge t appears with `out_valid[k]`=1 after edge t, i.e. in cycle t+1.
- Throughput: one word per cycle into any channel whose consumer keeps `out_ready`=1, including back-to-back writes to the same channel.
- There is no combinational path from `in_valid`/`in_data` to any output. The only combinational path is `out_ready`/`in_sel` → `in_ready`.
- Producers must hold `in_data`/`in_sel`/`in_bcast` stable while `in_valid` is high and `in_ready` is low. The block holds `out_data[k]` stable while `out_valid[k]` is high and `out_ready[k]` is low.
- `drop_err` is registered: high exactly one cycle per discarded word, asserted the cycle after the discard.

## Configuration
- Macro: `SDEMUX_BROADCAST_EN`.
- Defined: `in_bcast`=1 writes the word to every channel.
  - `in_ready` = AND over all k of `(!out_valid[k] || out_ready[k])`.
  - `in_sel` is ignored and no drop occurs.
  - All channels become FULL in the same cycle.
- Not defined: the `in_bcast` port remains in the port list but is ignored. Behaviour is identical to `in_bcast`=0, and no broadcast logic is synthesised.

## Test plan
- Reset then route: WIDTH=16, CHANNELS=8, all `out_ready`=1. Send 0x1234 sel 3. Expected: `out_valid`=0x08 and `out_data[3]`=0x1234 in the next cycle, then 0x00 after drain.
- Backpressure: `out_ready[2]`=0. Send 0xAAAA sel 2, then 0xBBBB sel 2. Expected: `in_ready`=0 on the second word; 0xAAAA held; after `out_ready[2]`=1 for one cycle, 0xBBBB is accepted that same cycle and appears next.
- Independence: channel 2 blocked and full. Send 0x5555 sel 5. Expected: accepted immediately; `out_valid`=0x24.
- Out-of-range drop: CHANNELS=6. Send sel 7 three times. Expected: `in_ready`=1, three `drop_err` pulses, `drop_cnt`=3, `out_valid` unchanged. Send 300 drops. Expected: `drop_cnt`=255.
- Async reset mid-stream: channels 0, 1 and 4 FULL; assert `rst_n`=0 between edges. Expected: `out_valid`=0 and `out_data`=0 immediately; `drop_cnt`=0.
- Broadcast (with `SDEMUX_BROADCAST_EN`): `in_bcast`=1, data 0xCAFE, `out_ready[6]`=0 with channel 6 FULL. Expected: `in_ready`=0. Raise `out_ready[6]`. Expected: all 8 `out_data`=0xCAFE next cycle. Without the macro, the same stimulus routes to `in_sel` only.
